dmem_responder: RTL and testbench

Word-addressed data-memory responder on the core's load/store port: accepts one request at a time over a valid/ready handshake and returns read data or a write acknowledge over a second valid/ready channel. Sits between the single-cycle core's data port and an on-chip RAM. Its configurable wait states let the core and its testbench exercise stall paths that a zero-latency memory hides.

---
 rtl/riscv_mem_pkg.sv | 35 +++
 rtl/dmem_responder_if.sv | 30 +++
 rtl/dmem_array.sv | 33 +++
 rtl/dmem_responder.sv | 131 +++++++++++++
 tb/tb_dmem_responder.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding,
// byte-lane count and byte-enable helpers.
package riscv_mem_pkg;

    localparam int BE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Expand a 4-bit byte enable into a 32-bit lane mask.
    function automatic logic [31:0] lane_mask(input logic [BE_W-1:0] be);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < BE_W; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

    // Byte-enable patterns a store may use once the address is word aligned:
    // single bytes, aligned halfwords and the full word.
    function automatic logic be_legal(input logic [BE_W-1:0] be);
        logic ok;
        case (be)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: ok = 1'b1;
            default:                   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between the core's load/store port (master) and the
// data-memory responder (slave). Two independent valid/ready channels.
interface dmem_responder_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    import riscv_mem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [BE_W-1:0]   req_be;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_array.sv
// Single-port synchronous RAM, DEPTH_WORDS x 32, one storage array per byte
// lane so each lane has its own write enable. Read data is registered
// (read-first) and held until the next enabled access.
module dmem_array
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    localparam int IDX_W      = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             en,
    input  logic [BE_W-1:0]  we,
    input  logic [IDX_W-1:0] addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    for (genvar i = 0; i < BE_W; i++) begin : g_lane
        logic [7:0] mem [DEPTH_WORDS];
        logic [7:0] q;

        // One byte lane: optional write, registered read of the old contents.
        always_ff @(posedge clk) begin
            if (en) begin
                if (we[i]) mem[addr] <= wdata[8*i +: 8];
                q <= mem[addr];
            end
        end

        assign rdata[8*i +: 8] = q;
    end

endmodule

// File: rtl/dmem_responder.sv
// Word-addressed data-memory responder. Accepts one load/store at a time,
// waits WAIT_CYCLES extra cycles, performs the RAM access, then presents the
// response until the core takes it.
// Optional feature macro: DMEM_MISALIGN_CHECK_EN -- when defined, misaligned
// addresses and irregular store byte enables are reported as errors; when
// undefined, addr[1:0] is ignored and only out-of-range addresses error.
module dmem_responder
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst,
    dmem_responder_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WAIT_CYCLES);
    localparam logic [ADDR_W-3:0] DEPTH_LIM = (ADDR_W-2)'(DEPTH_WORDS);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [BE_W-1:0]   lat_be;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;

    logic              oor_err;
    logic              mis_err;
    logic              acc_err;
    logic              access;
    logic              ram_en;
    logic [BE_W-1:0]   ram_we;
    logic [DATA_W-1:0] ram_q;

    // Error classification works on the latched request only.
    assign oor_err = lat_addr[ADDR_W-1:2] >= DEPTH_LIM;
`ifdef DMEM_MISALIGN_CHECK_EN
    assign mis_err = (lat_addr[1:0] != 2'b00) || (lat_we && !be_legal(lat_be));
`else
    assign mis_err = 1'b0;
`endif
    assign acc_err = oor_err || mis_err;

    // The RAM access lands on the WAIT->RESP edge, so the registered read
    // data is already valid in the first RESP cycle. Errors never touch RAM.
    assign access = (state == WAIT) && (cnt == CNT_LAST);
    assign ram_en = access && !acc_err;
    assign ram_we = lat_we ? lat_be : '0;

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk  (clk),
        .en   (ram_en),
        .we   (ram_we),
        .addr (lat_addr[IDX_W+1:2]),
        .wdata(lat_wdata),
        .rdata(ram_q)
    );

    // Request/response FSM with registered handshake outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            lat_we      <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            lat_be      <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid && req_ready_q) begin
                        lat_we      <= bus.req_we;
                        lat_addr    <= bus.req_addr;
                        lat_wdata   <= bus.req_wdata;
                        lat_be      <= bus.req_be;
                        cnt         <= '0;
                        req_ready_q <= 1'b0;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == CNT_LAST) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= acc_err;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    // Returning to IDLE here (not accepting) keeps a new
                    // request out of the response-completion cycle.
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        req_ready_q <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    req_ready_q <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    // Load data is masked to the enabled lanes; stores and errors return 0.
    // Gating on the registered valid also gives 0 out of reset.
    assign bus.rsp_rdata = (rsp_valid_q && !rsp_err_q && !lat_we)
                           ? (ram_q & lane_mask(lat_be)) : '0;
    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed cases with literal expectations plus
// randomized traffic, all checked each cycle against a timing/memory model.
module tb_dmem_responder;

    parameter int W = 2;
    localparam int DEPTH = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_responder_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dmem_responder #(
        .ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: memory image and the transaction in flight.
    logic [31:0] mdl [DEPTH];
    bit          busy = 0;
    int          acc  = 0;
    logic [31:0] exp_rdata;
    bit          exp_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] m_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    function automatic bit m_err(input bit we, input logic [31:0] addr, input logic [3:0] be);
        bit e;
        e = (addr >> 2) >= DEPTH;
`ifdef DMEM_MISALIGN_CHECK_EN
        if (addr[1:0] != 2'b00) e = 1;
        if (we && !(be inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111})) e = 1;
`endif
        return e;
    endfunction

    // Per-cycle compare: handshake timing from the accept cycle, data from the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
            chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
            chk("rst_rsp_err",   32'(bus.rsp_err), 32'd0);
        end else if (!busy) begin
            chk("idle_req_ready", 32'(bus.req_ready), 32'd1);
            chk("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        end else begin
            chk("busy_req_ready", 32'(bus.req_ready), 32'd0);
            chk("rsp_valid_timing", 32'(bus.rsp_valid), (cyc >= acc + W + 1) ? 32'd1 : 32'd0);
            if (cyc >= acc + W + 1) begin
                chk("rsp_rdata", bus.rsp_rdata, exp_rdata);
                chk("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
            end
        end
    end

    // Request inputs are ignored outside the accept edge; keep them noisy.
    task automatic scramble();
        bus.req_valid = 1'($urandom);
        bus.req_we    = 1'($urandom);
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        bus.req_be    = 4'($urandom);
    endtask

    // Accept on the next edge; called and returning at posedge+1 with the model idle.
    task automatic accept(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_be    = be;
        bus.rsp_ready = 1'b0;
        @(posedge clk); #1;
        busy      = 1;
        acc       = cyc;
        exp_err   = m_err(we, addr, be);
        exp_rdata = (!we && !exp_err) ? (mdl[int'(addr >> 2)] & m_mask(be)) : 32'd0;
        scramble();
    endtask

    task automatic txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input int stall,
                       output logic [31:0] obs_rdata, output logic obs_err);
        int w;
        accept(we, addr, wdata, be);
        while (cyc < acc + W + 1) begin
            @(posedge clk); #1;
            scramble();
        end
        obs_rdata = bus.rsp_rdata;
        obs_err   = bus.rsp_err;
        if (we && !exp_err) begin
            w = int'(addr >> 2);
            mdl[w] = (mdl[w] & ~m_mask(be)) | (wdata & m_mask(be));
        end
        repeat (stall) begin
            @(posedge clk); #1;
            scramble();
            bus.req_valid = 1'b1;
        end
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        busy = 0;
        bus.rsp_ready = 1'b0;
    endtask

    // Store abandoned by reset before its write edge.
    task automatic reset_txn(input logic [31:0] addr, input logic [31:0] wdata);
        accept(1'b1, addr, wdata, 4'hF);
        if (W > 0) begin
            @(posedge clk); #1;
        end
        rst  = 1'b0;
        busy = 0;
        bus.req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
    endtask

    logic [31:0] r;
    logic        e;

    initial begin
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_be    = '0;
        bus.rsp_ready = 1'b0;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        // Seed words 0..15 so every later load has defined contents.
        for (int i = 0; i < 16; i++) txn(1'b1, 32'(i * 4), $urandom, 4'hF, 1, r, e);

        // Store then load.
        txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, r, e);
        chk("store_err", 32'(e), 32'd0);
        chk("store_rdata", r, 32'd0);
        txn(1'b0, 32'h10, 32'h0, 4'hF, 0, r, e);
        chk("load_full", r, 32'hDEADBEEF);
        chk("load_full_err", 32'(e), 32'd0);

        // Partial write and partial read.
        txn(1'b1, 32'h10, 32'h000000AA, 4'b0001, 0, r, e);
        txn(1'b0, 32'h10, 32'h0, 4'hF, 0, r, e);
        chk("partial_write", r, 32'hDEADBEAA);
        txn(1'b0, 32'h10, 32'h0, 4'b0011, 0, r, e);
        chk("partial_read", r, 32'h0000BEAA);

        // Backpressure for 5 cycles; stability is checked every cycle.
        txn(1'b0, 32'h10, 32'h0, 4'hF, 5, r, e);
        chk("backpressure_rdata", r, 32'hDEADBEAA);

        // Out-of-range load.
        txn(1'b0, 32'(DEPTH * 4), 32'h0, 4'hF, 1, r, e);
        chk("oor_err", 32'(e), 32'd1);
        chk("oor_rdata", r, 32'd0);
        txn(1'b1, 32'hFFFF_FFF0, 32'h5555_5555, 4'hF, 0, r, e);
        chk("oor_store_err", 32'(e), 32'd1);

`ifdef DMEM_MISALIGN_CHECK_EN
        txn(1'b1, 32'h12, 32'hFFFF_FFFF, 4'hF, 0, r, e);
        chk("misalign_err", 32'(e), 32'd1);
        txn(1'b0, 32'h10, 32'h0, 4'hF, 0, r, e);
        chk("misalign_no_write", r, 32'hDEADBEAA);
`endif

        // Reset during WAIT discards the store.
        txn(1'b1, 32'h20, 32'h0, 4'hF, 0, r, e);
        reset_txn(32'h20, 32'h12345678);
        txn(1'b0, 32'h20, 32'h0, 4'hF, 0, r, e);
        chk("reset_discard", r, 32'd0);

        // Randomized traffic, mostly in the seeded window, some out of range.
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            int sel;
            sel = $urandom_range(0, 19);
            if (sel == 0)      a = 32'(DEPTH * 4) + 32'($urandom_range(0, 4000));
            else if (sel == 1) a = $urandom | 32'h8000_0000;
            else               a = 32'($urandom_range(0, 15) * 4) | 32'($urandom_range(0, 3));
            txn(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3), r, e);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
